// File: rtl/sysbus_mem_responder.sv
// Memory-side responder for the 64-bit system bus.
// Serves 64-byte line reads as 8-beat bursts and absorbs 8-beat line writes,
// backed by an internal word array that the bench can preload via init_*.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      init_we,
  input  logic [31:0]               init_addr,
  input  logic [BUS_DATA_WIDTH-1:0] init_data,
  output logic                      busy,
  output logic                      oob_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - 3;                       // line index width
  localparam int CW = $clog2(READ_LATENCY) + 1;
  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_SEND, WR_DATA} state_t;

  state_t                     state_reg;
  logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];
  logic [LW-1:0]              line_reg;
  logic [2:0]                 start_reg;
  logic [2:0]                 beat_reg;
  logic                       oob_reg;
  logic [CW-1:0]              lat_cnt_reg;
  logic [BUS_TAG_WIDTH-1:0]   tag_reg;

  // Header decode: the last word of the addressed line decides out-of-bounds.
  logic [BUS_DATA_WIDTH-1:0]  hdr_last;
  logic [LW-1:0]              hdr_line;
  logic [2:0]                 unused_low_bits;
  assign hdr_last        = {3'b000, bus_req[BUS_DATA_WIDTH-1:6], 3'b111};
  assign hdr_line        = bus_req[AW+2:6];
  assign unused_low_bits = bus_req[2:0];

  assign bus_reqack = bus_reqcyc && (state_reg == IDLE || state_reg == WR_DATA) && !reset;
  assign busy       = (state_reg != IDLE);

  // Word offsets inside the line; the 3-bit adds wrap around the line.
  logic [2:0]    rd_off;
  logic [2:0]    wr_off;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic          init_hit;

  // Next word to load into bus_resp: beat 0 while waiting, beat+1 while sending.
  always_comb begin
    rd_off = start_reg;
    if (state_reg == RD_SEND) rd_off = start_reg + beat_reg + 3'd1;
  end

  assign wr_off   = start_reg + beat_reg;
  assign rd_idx   = {line_reg, rd_off};
  assign wr_idx   = {line_reg, wr_off};
  assign wr_en    = (state_reg == WR_DATA) && bus_reqack && !oob_reg;
  assign init_hit = init_we && (init_addr < 32'(MEM_WORDS));

  // Array write port: bus write is ordered last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (init_hit) mem[init_addr[AW-1:0]] <= init_data;
    if (wr_en)    mem[wr_idx] <= bus_req;
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      oob_err     <= 1'b0;
      line_reg    <= '0;
      start_reg   <= '0;
      beat_reg    <= '0;
      oob_reg     <= 1'b0;
      lat_cnt_reg <= '0;
      tag_reg     <= '0;
    end else begin
      oob_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus_reqack) begin
            line_reg  <= hdr_line;
            start_reg <= bus_req[5:3];
            beat_reg  <= '0;
            oob_reg   <= (hdr_last >= BUS_DATA_WIDTH'(MEM_WORDS));
            oob_err   <= (hdr_last >= BUS_DATA_WIDTH'(MEM_WORDS));
            if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
              tag_reg     <= bus_reqtag;
              lat_cnt_reg <= CW'(READ_LATENCY - 1);
              state_reg   <= RD_WAIT;
            end else begin
              state_reg   <= WR_DATA;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt_reg == '0) begin
            state_reg   <= RD_SEND;
            bus_respcyc <= 1'b1;
            bus_resp    <= oob_reg ? '0 : mem[rd_idx];
            bus_resptag <= tag_reg;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        RD_SEND: begin
          if (bus_respack) begin
            if (beat_reg == LAST_BEAT) begin
              state_reg   <= IDLE;
              bus_respcyc <= 1'b0;
            end else begin
              beat_reg <= beat_reg + 3'd1;
              bus_resp <= oob_reg ? '0 : mem[rd_idx];
            end
          end
        end
        WR_DATA: begin
          if (bus_reqcyc) begin
            if (beat_reg == LAST_BEAT) state_reg <= IDLE;
            else                       beat_reg  <= beat_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed plus randomized checks of sysbus_mem_responder against a simple
// word-array model of the bus memory.
module tb_sysbus_mem_responder;

  localparam int MEMW = 4096;
  localparam int LAT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        init_we;
  logic [31:0] init_addr;
  logic [63:0] init_data;
  logic        busy;
  logic        oob_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_mem [MEMW];

  sysbus_mem_responder dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .busy(busy), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read one line; optional respack stall on one beat, optional reset at a beat.
  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                         input int stall_beat, input int stall_len, input int abort_at);
    logic [63:0] exp_d [8];
    logic [63:0] base;
    int start, t, stall_left, cycles;
    bit oob;
    base  = (addr >> 3) & ~64'd7;
    start = int'((addr >> 3) % 8);
    oob   = (base + 64'd7) >= 64'(MEMW);
    for (int b = 0; b < 8; b++) begin
      if (oob) exp_d[b] = 64'd0;
      else     exp_d[b] = model_mem[int'(base) + ((start + b) % 8)];
    end
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b1;
    #1;
    chk("rd_hdr_ack", bus_reqack, 1);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    chk("rd_oob_pulse", oob_err, oob);
    chk("rd_busy", busy, 1);
    cycles = 0;
    while (!bus_respcyc && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) chk("rd_oob_clear", oob_err, 0);
    end
    chk("rd_latency", cycles, LAT);
    t = 0;
    stall_left = stall_len;
    while (t < 8) begin
      if (t == abort_at) begin
        reset = 1'b1; bus_respack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_respcyc", bus_respcyc, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        chk("abort_no_beat", bus_respcyc, 0);
        $display("read addr=%h tag=%h aborted at beat %0d", addr, tag, t);
        return;
      end
      if (t == stall_beat && stall_left > 0) begin
        bus_respack = 1'b0; stall_left--;
      end else begin
        bus_respack = 1'b1;
      end
      #1;
      chk("rd_valid", bus_respcyc, 1);
      chk("rd_data", bus_resp, exp_d[t]);
      chk("rd_tag", bus_resptag, tag);
      if (bus_respack) t++;
      @(negedge clk);
    end
    bus_respack = 1'b1;
    #1;
    chk("rd_end_respcyc", bus_respcyc, 0);
    chk("rd_end_busy", busy, 0);
    $display("read addr=%h tag=%h oob=%0d stall=%0d/%0d", addr, tag, oob, stall_beat, stall_len);
  endtask

  // Write one line; optional reqcyc gap and random init_we collisions.
  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input bit rnd,
                          input logic [63:0] d0, input int gap_after, input int gap_len,
                          input bit collide);
    logic [63:0] base, dat, idat;
    int start, t, gl, guard, w, ia;
    bit oob;
    base  = (addr >> 3) & ~64'd7;
    start = int'((addr >> 3) % 8);
    oob   = (base + 64'd7) >= 64'(MEMW);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b1;
    #1;
    chk("wr_hdr_ack", bus_reqack, 1);
    @(negedge clk);
    chk("wr_oob_pulse", oob_err, oob);
    chk("wr_busy", busy, 1);
    t = 0; gl = gap_len; guard = 0;
    while (t < 8 && guard < 40) begin
      guard++;
      if (t == gap_after + 1 && gl > 0) begin
        bus_reqcyc = 1'b0; gl--;
        #1;
        chk("wr_gap_noack", bus_reqack, 0);
      end else begin
        dat = rnd ? {$urandom, $urandom} : d0 + 64'(t);
        w = oob ? 0 : int'(base) + ((start + t) % 8);
        bus_reqcyc = 1'b1; bus_req = dat;
        if (collide && $urandom_range(0, 3) == 0) begin
          ia   = (!oob && $urandom_range(0, 1) == 1) ? w : int'($urandom_range(0, 4200));
          idat = {$urandom, $urandom};
          init_we = 1'b1; init_addr = 32'(ia); init_data = idat;
          if (ia < MEMW) model_mem[ia] = idat;
        end
        #1;
        chk("wr_beat_ack", bus_reqack, 1);
        if (!oob) model_mem[w] = dat;
        t++;
      end
      chk("wr_no_resp", bus_respcyc, 0);
      @(negedge clk);
      init_we = 1'b0;
    end
    bus_reqcyc = 1'b0;
    #1;
    chk("wr_end_busy", busy, 0);
    $display("write addr=%h tag=%h oob=%0d gap=%0d", addr, tag, oob, gap_len);
  endtask

  logic [63:0] raddr;

  initial begin
    reset = 1'b1; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b1;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    repeat (3) @(negedge clk);
    bus_reqcyc = 1'b1; bus_req = 64'h200; bus_reqtag = 13'h1005;
    #1;
    chk("rst_reqack", bus_reqack, 0);
    chk("rst_respcyc", bus_respcyc, 0);
    chk("rst_resp", bus_resp, 0);
    chk("rst_resptag", bus_resptag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oob_err", oob_err, 0);
    bus_reqcyc = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Backdoor preload of the whole array, then the directed pattern.
    for (int i = 0; i < MEMW; i++) begin
      init_we = 1'b1; init_addr = 32'(i); init_data = {$urandom, $urandom};
      model_mem[i] = init_data;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      init_we = 1'b1; init_addr = 32'(64 + i); init_data = 64'h1000 + 64'(i);
      model_mem[64 + i] = init_data;
      @(negedge clk);
    end
    init_we = 1'b1; init_addr = 32'(MEMW + 5); init_data = 64'hDEAD;
    @(negedge clk);
    init_we = 1'b0;
    $display("preload done");

    do_read(64'h200, 13'h1005, 8, 0, 8);
    do_read(64'h218, 13'h1006, 8, 0, 8);
    do_write(64'h400, 13'h0001, 1'b0, 64'hA0, 3, 2, 1'b0);
    do_read(64'h400, 13'h1002, 8, 0, 8);
    do_read(64'h200, 13'h1007, 2, 3, 8);
    do_read(64'h8000, 13'h1008, 8, 0, 8);
    do_write(64'h8000, 13'h0009, 1'b0, 64'hB0, 0, 0, 1'b0);
    do_read(64'h200, 13'h100A, 8, 0, 4);
    do_read(64'h200, 13'h100B, 8, 0, 8);
    do_read(64'h400, 13'h100C, 8, 0, 8);

    // Randomized traffic against the word-array model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) raddr = {$urandom, $urandom} | 64'h0000_0001_0000_0000;
      else raddr = {49'd0, 12'($urandom_range(0, MEMW - 1)), 3'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_read(raddr, 13'h1000 | 13'($urandom_range(0, 4095)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8);
      else
        do_write(raddr, 13'($urandom_range(0, 4095)), 1'b1, 64'd0,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
